// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers column/row position, the active-video
// window and frame markers from an HSync/VSync pair, and tracks lock to nominal timing.
module vga_sync_decoder #(
  parameter int TOTAL_COLS      = 800,
  parameter int TOTAL_ROWS      = 525,
  parameter int ACTIVE_COLS     = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int H_ACT_OFS       = 144,
  parameter int V_ACT_OFS       = 35,
  parameter int LOCK_FRAMES     = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic [9:0] o_Pixel_X,
  output logic [9:0] o_Pixel_Y,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic       o_Locked,
  output logic       o_Err
);

  localparam logic [10:0] COL_MAX   = 11'd2047;
  localparam logic [9:0]  ROW_MAX   = 10'd1023;
  localparam logic [10:0] LINE_END  = 11'(TOTAL_COLS - 1);
  localparam logic [9:0]  FRAME_END = 10'(TOTAL_ROWS - 1);

  // The row counter saturates at 1023, so a lost-VSync limit above that is clamped
  // to the saturation value; otherwise a dead VSync could never be noticed.
  localparam int          COL_LIMIT_I = (2 * TOTAL_COLS > 2047) ? 2047 : 2 * TOTAL_COLS;
  localparam int          ROW_LIMIT_I = (2 * TOTAL_ROWS > 1023) ? 1023 : 2 * TOTAL_ROWS;
  localparam logic [10:0] COL_LIMIT   = 11'(COL_LIMIT_I);
  localparam logic [9:0]  ROW_LIMIT   = 10'(ROW_LIMIT_I);

  localparam logic [10:0] H_START = 11'(H_ACT_OFS);
  localparam logic [10:0] H_END   = 11'(H_ACT_OFS + ACTIVE_COLS);
  localparam logic [9:0]  V_START = 10'(V_ACT_OFS);
  localparam logic [9:0]  V_END   = 10'(V_ACT_OFS + ACTIVE_ROWS);

  localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_t;

  state_t          state;
  logic [10:0]     col;
  logic [9:0]      row;
  logic [GW-1:0]   good_cnt;
  logic            line_fail;
  logic            hs_q;
  logic            vs_q;

  // Sync levels normalised so that 1 always means "asserted".
  logic hs_in, vs_in;
  logic hs_lead, vs_lead;
  logic line_bad, frame_ok;
  logic h_timeout, v_timeout;
  logic act_now;

  assign hs_in     = SYNC_ACTIVE_LOW ? ~i_HSync : i_HSync;
  assign vs_in     = SYNC_ACTIVE_LOW ? ~i_VSync : i_VSync;
  assign hs_lead   = hs_in & ~hs_q;
  assign vs_lead   = vs_in & ~vs_q;

  // Checks look at the count before this cycle's update.
  assign line_bad  = hs_lead && (col != LINE_END);
  assign frame_ok  = (row == FRAME_END) && !line_fail && !line_bad;
  assign h_timeout = (col >= COL_LIMIT) && !hs_lead;
  assign v_timeout = (row >= ROW_LIMIT) && !vs_lead;

  assign act_now   = (state == LOCKED) &&
                     (col >= H_START) && (col < H_END) &&
                     (row >= V_START) && (row < V_END);

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of block ordering.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      col  <= '0;
      row  <= '0;
    end else begin
      hs_q <= hs_in;
      vs_q <= vs_in;

      if (hs_lead)             col <= '0;
      else if (col != COL_MAX) col <= col + 11'd1;

      if (vs_lead)                        row <= '0;
      else if (hs_lead && row != ROW_MAX) row <= row + 10'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= SEARCH;
      good_cnt      <= '0;
      line_fail     <= 1'b0;
      o_Locked      <= 1'b0;
      o_Err         <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else begin
      o_Err         <= 1'b0;
      o_Frame_Start <= vs_lead && (state != SEARCH);

      if (h_timeout || v_timeout) begin
        // Lost sync entirely: drop silently and wait for a fresh VSync.
        state     <= SEARCH;
        o_Locked  <= 1'b0;
        good_cnt  <= '0;
        line_fail <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (vs_lead) begin
              state     <= TRACK;
              good_cnt  <= '0;
              line_fail <= 1'b0;
            end
          end

          TRACK: begin
            if (vs_lead) begin
              line_fail <= 1'b0;
              if (!frame_ok) begin
                good_cnt <= '0;
              end else if (good_cnt == GW'(LOCK_FRAMES - 1)) begin
                state    <= LOCKED;
                o_Locked <= 1'b1;
                good_cnt <= good_cnt + GW'(1);
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end else if (line_bad) begin
              line_fail <= 1'b1;
            end
          end

          LOCKED: begin
            if (line_bad || (vs_lead && !frame_ok)) begin
              o_Err     <= 1'b1;
              state     <= TRACK;
              o_Locked  <= 1'b0;
              good_cnt  <= '0;
              // A mid-frame failure taints the frame in progress; one at VSync
              // closes the old frame and the new one starts clean.
              line_fail <= !vs_lead;
            end else if (vs_lead) begin
              line_fail <= 1'b0;
            end
          end

          default: begin
            state    <= SEARCH;
            o_Locked <= 1'b0;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Active  <= 1'b0;
      o_Pixel_X <= '0;
      o_Pixel_Y <= '0;
    end else begin
      o_Active  <= act_now;
      o_Pixel_X <= act_now ? 10'(col - H_START) : 10'd0;
      o_Pixel_Y <= act_now ? 10'(row - V_START) : 10'd0;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a scaled-down raster: the stimulus pushes
// expected pixels/pulses/lock edges, a negedge monitor pops and compares them.
module tb_vga_sync_decoder;

  localparam int TC  = 40;  // clocks per line
  localparam int TR  = 20;  // lines per frame
  localparam int AC  = 24;
  localparam int AR  = 12;
  localparam int HO  = 10;
  localparam int VO  = 4;
  localparam int HSW = 4;   // HSync width in clocks
  localparam int VSW = 2;   // VSync width in lines

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic hs_act, vs_act;
  logic hs_n, vs_n;
  logic sel;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign hs_n = ~hs_act;
  assign vs_n = ~vs_act;

  logic [9:0] px1, py1, px2, py2;
  logic       act1, fs1, lk1, err1, act2, fs2, lk2, err2;

  vga_sync_decoder #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_ACT_OFS(HO), .V_ACT_OFS(VO), .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1'b1)
  ) u_dut_low (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hs_n), .i_VSync(vs_n),
    .o_Pixel_X(px1), .o_Pixel_Y(py1), .o_Active(act1),
    .o_Frame_Start(fs1), .o_Locked(lk1), .o_Err(err1)
  );

  vga_sync_decoder #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_ACT_OFS(HO), .V_ACT_OFS(VO), .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1'b0)
  ) u_dut_high (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hs_act), .i_VSync(vs_act),
    .o_Pixel_X(px2), .o_Pixel_Y(py2), .o_Active(act2),
    .o_Frame_Start(fs2), .o_Locked(lk2), .o_Err(err2)
  );

  logic [9:0]  mon_x, mon_y;
  logic        mon_act, mon_fs, mon_lk, mon_err;
  logic [23:0] mon_all;

  assign mon_x   = sel ? px2  : px1;
  assign mon_y   = sel ? py2  : py1;
  assign mon_act = sel ? act2 : act1;
  assign mon_fs  = sel ? fs2  : fs1;
  assign mon_lk  = sel ? lk2  : lk1;
  assign mon_err = sel ? err2 : err1;
  assign mon_all = {mon_x, mon_y, mon_act, mon_fs, mon_lk, mon_err};

  typedef struct { int cyc; int x; int y; } pix_t;
  typedef struct { int cyc; bit val; }      lk_t;

  pix_t q_pix[$];
  int   q_fs[$];
  int   q_err[$];
  lk_t  q_lk[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic longint pack3(input int a, input int b, input int c);
    return (longint'(a) << 32) | (longint'(b & 'hFFFF) << 16) | longint'(c & 'hFFFF);
  endfunction

  // Monitor: consumes one scoreboard entry per observed output event.
  pix_t p_cur;
  lk_t  l_cur;
  logic prev_lk = 1'b0;

  always @(negedge clk) begin
    if (mon_act) begin
      check("pixel_expected", longint'(q_pix.size() != 0), 1);
      if (q_pix.size() != 0) begin
        p_cur = q_pix.pop_front();
        check("pixel", pack3(cyc, int'(mon_x), int'(mon_y)), pack3(p_cur.cyc, p_cur.x, p_cur.y));
      end
    end else begin
      check("pixel_idle_zero", longint'({mon_x, mon_y}), 0);
    end

    if (mon_fs) begin
      check("frame_start_expected", longint'(q_fs.size() != 0), 1);
      if (q_fs.size() != 0) check("frame_start_cycle", cyc, q_fs.pop_front());
    end

    if (mon_err) begin
      check("err_expected", longint'(q_err.size() != 0), 1);
      if (q_err.size() != 0) check("err_cycle", cyc, q_err.pop_front());
    end

    if (mon_lk !== prev_lk) begin
      check("lock_edge_expected", longint'(q_lk.size() != 0), 1);
      if (q_lk.size() != 0) begin
        l_cur = q_lk.pop_front();
        check("lock_edge", pack3(cyc, int'(mon_lk), 0), pack3(l_cur.cyc, int'(l_cur.val), 0));
      end
    end
    prev_lk = mon_lk;
  end

  // One raster cell: inputs change 1 time unit after the edge, sampled at the next edge.
  task automatic drive_cell(input bit hs, input bit vs);
    @(posedge clk);
    #1;
    hs_act = hs;
    vs_act = vs;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive_cell(1'b0, 1'b0);
  endtask

  // lk: -1 no lock edge at this frame's VSync, 0 falling, 1 rising.
  // err_line: line whose leading HSync edge is expected to raise o_Err (-1 none).
  task automatic drive_frame(input int rows, input int long_line, input bit fs, input int lk,
                             input bit err_vs, input int err_line, input bit act,
                             input int stop_line = -1, input int stop_col = 0);
    int k;
    int len;
    for (int l = 0; l < rows; l++) begin
      len = (l == long_line) ? TC + 1 : TC;
      for (int c = 0; c < len; c++) begin
        if (l == stop_line && c == stop_col) return;
        drive_cell(c < HSW, l < VSW);
        k = cyc;
        if (l == 0 && c == 0) begin
          if (fs)      q_fs.push_back(k + 1);
          if (lk >= 0) q_lk.push_back(lk_t'{k + 1, bit'(lk)});
          if (err_vs)  q_err.push_back(k + 1);
        end
        if (l == err_line && c == 0) begin
          q_err.push_back(k + 1);
          q_lk.push_back(lk_t'{k + 1, 1'b0});
        end
        if (act && l >= VO && l < VO + AR && c >= HO && c < HO + AC)
          q_pix.push_back(pix_t'{k + 2, c - HO, l - VO});
      end
    end
  endtask

  // Called right after a drive: asserts reset mid-cycle and checks it acts asynchronously.
  task automatic reset_mid(input bit was_locked, input bit new_sel);
    #2;
    q_pix.delete();
    q_fs.delete();
    q_err.delete();
    q_lk.delete();
    if (was_locked) q_lk.push_back(lk_t'{cyc, 1'b0});
    rst_n = 1'b0;
    #1 check("async_reset_outputs", longint'(mon_all), 0);
    sel = new_sel;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Nominal acquisition: SEARCH->TRACK, two good frames, then two locked frames.
  task automatic nominal_lock_sequence();
    drive_frame(TR, -1, 1'b0, -1, 1'b0, -1, 1'b0);
    drive_frame(TR, -1, 1'b1, -1, 1'b0, -1, 1'b0);
    drive_frame(TR, -1, 1'b1,  1, 1'b0, -1, 1'b1);
    drive_frame(TR, -1, 1'b1, -1, 1'b0, -1, 1'b1);
  endtask

  int k0;

  initial begin
    hs_act = 1'b0;
    vs_act = 1'b0;
    sel    = 1'b0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #2 check("reset_state", longint'(mon_all), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_idle(10);

    // Nominal stream: lock after the third VSync, full windows in locked frames.
    nominal_lock_sequence();

    // 41-clock line at line 1: error on the next HSync, relock after two clean frames.
    drive_frame(TR,  1, 1'b1, -1, 1'b0,  2, 1'b0);
    drive_frame(TR, -1, 1'b1, -1, 1'b0, -1, 1'b0);
    drive_frame(TR, -1, 1'b1, -1, 1'b0, -1, 1'b0);
    drive_frame(TR, -1, 1'b1,  1, 1'b0, -1, 1'b1);

    // HSync stops after one line: silent drop to SEARCH once col hits 2*TC.
    k0 = cyc + 1;
    drive_frame(1, -1, 1'b1, -1, 1'b0, -1, 1'b0);
    q_lk.push_back(lk_t'{k0 + 2 * TC + 2, 1'b0});
    drive_idle(2 * TC);

    // Reacquire, then a short frame (TR-1 lines) while locked.
    drive_frame(TR,     -1, 1'b0, -1, 1'b0, -1, 1'b0);
    drive_frame(TR,     -1, 1'b1, -1, 1'b0, -1, 1'b0);
    drive_frame(TR,     -1, 1'b1,  1, 1'b0, -1, 1'b1);
    drive_frame(TR - 1, -1, 1'b1, -1, 1'b0, -1, 1'b1);
    drive_frame(TR,     -1, 1'b1,  0, 1'b1, -1, 1'b0);
    drive_frame(TR,     -1, 1'b1, -1, 1'b0, -1, 1'b0);
    drive_frame(TR,     -1, 1'b1,  1, 1'b0, -1, 1'b1);

    // Reset mid-line inside the active region of a locked frame.
    drive_frame(TR, -1, 1'b1, -1, 1'b0, -1, 1'b1, 8, 20);
    reset_mid(1'b1, 1'b0);
    drive_idle(30);
    drive_frame(TR, -1, 1'b0, -1, 1'b0, -1, 1'b0);
    drive_frame(TR, -1, 1'b1, -1, 1'b0, -1, 1'b0);
    drive_frame(TR, -1, 1'b1,  1, 1'b0, -1, 1'b1);

    // Active-high instance, same logical stream as the nominal run.
    reset_mid(1'b1, 1'b1);
    drive_idle(10);
    nominal_lock_sequence();
    drive_idle(5);

    check("pixels_outstanding",      q_pix.size(), 0);
    check("frame_starts_outstanding", q_fs.size(),  0);
    check("errs_outstanding",        q_err.size(), 0);
    check("lock_edges_outstanding",  q_lk.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: consumes the HSync/VSync pair and recovers column/row position, active-video window and frame markers.
- Runs a lock state machine that checks line and frame lengths against nominal 640x480@60 timing.
- Sits downstream of the VGA generator (loopback/self-check) or in front of any pixel consumer that only sees sync signals.
- HSync/VSync are synchronous to i_Clk; no CDC is handled inside this block.

Parameters:
- TOTAL_COLS, 800, clocks per line, measured leading edge to leading edge.
- TOTAL_ROWS, 525, lines per frame.
- ACTIVE_COLS, 640, visible pixels per line.
- ACTIVE_ROWS, 480, visible lines per frame.
- H_ACT_OFS, 144, clocks from HSync leading edge to first visible pixel (sync 96 + back porch 48).
- V_ACT_OFS, 35, lines from VSync leading edge to first visible line (sync 2 + back porch 33).
- LOCK_FRAMES, 2, consecutive good frames required to assert lock.
- SYNC_ACTIVE_LOW, 1, 1 = sync asserted when low.

Ports:
- i_Clk  in  1  pixel clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_HSync  in  1  horizontal sync.
- i_VSync  in  1  vertical sync.
- o_Pixel_X  out  10  active-area column; 0 when o_Active=0.
- o_Pixel_Y  out  10  active-area row; 0 when o_Active=0.
- o_Active  out  1  current position is visible video and decoder is locked.
- o_Frame_Start  out  1  one-cycle pulse on each VSync leading edge.
- o_Locked  out  1  timing matches parameters.
- o_Err  out  1  one-cycle pulse on a length mismatch while LOCKED.

Behaviour:
- Reset: asynchronous, active-low (i_Rst_L).
  - All outputs 0. State SEARCH. Internal col=0, row=0, good-frame count=0.
  - Sync history registers reset to the deasserted level.
- Edge detect: sync inputs are registered once.
  - hs_lead = input asserted AND registered copy deasserted; vs_lead likewise.
  - Trailing edges are ignored.
- Column counter (11 bit):
  - On hs_lead, col becomes 0 on the next clock.
  - Otherwise col increments by 1, saturating at 2047.
- Row counter (10 bit):
  - On hs_lead, row increments by 1, saturating at 1023.
  - On vs_lead, row becomes 0. vs_lead takes priority when it coincides with hs_lead.
- Checks, made on the pre-update count:
  - Line check at every hs_lead: good if col == TOTAL_COLS-1.
  - Frame check at every vs_lead: good if row == TOTAL_ROWS-1 and no line check has failed since the previous vs_lead.
- FSM:
  - SEARCH -> TRACK on first vs_lead. Clear good count and the line-fail flag.
  - TRACK:
    - Good frame check: good count +1. When the count reaches LOCK_FRAMES -> LOCKED, o_Locked=1 from the next cycle.
    - Bad frame check: good count := 0, stay in TRACK.
  - LOCKED:
    - A failed line check -> o_Err pulses one cycle, -> TRACK, o_Locked=0 on the next cycle, good count := 0.
    - A failed frame check does the same.
  - Any state: col reaching 2*TOTAL_COLS without hs_lead, or row reaching 2*TOTAL_ROWS without vs_lead -> SEARCH, o_Locked=0, no o_Err.
- Active window (registered, one cycle behind the counters):
  - o_Active=1 iff LOCKED and H_ACT_OFS <= col < H_ACT_OFS+ACTIVE_COLS and V_ACT_OFS <= row < V_ACT_OFS+ACTIVE_ROWS.
  - When active, o_Pixel_X = col-H_ACT_OFS and o_Pixel_Y = row-V_ACT_OFS; otherwise both 0.
- o_Frame_Start pulses in the cycle after vs_lead is detected, in every state except SEARCH.
- Reset asserted mid-frame: immediate return to the reset values; reacquisition needs a fresh vs_lead plus LOCK_FRAMES good frames.
- SYNC_ACTIVE_LOW=0: inputs are used uninverted; all other behaviour is identical.

Test Plan:
- Drive nominal 800x525 timing from the VGA generator for 4 frames.
  - o_Locked rises in the cycle after the 3rd vs_lead: first vs_lead enters TRACK, then 2 good frames.
  - Exactly 640x480 o_Active cycles per locked frame; first active sample X=0,Y=0; last X=639,Y=479.
- Locked stream, insert one 801-clock line in frame 5.
  - o_Err single pulse at that hs_lead; o_Locked=0 next cycle.
  - Relock after 2 further good frames.
- Hold HSync deasserted for 1600 clocks while locked.
  - Return to SEARCH; o_Locked=0, o_Err stays 0, o_Active=0.
- Frame of 524 lines.
  - o_Err at the vs_lead; o_Frame_Start still pulses.
  - Good count restarts: 2 good frames are needed before lock.
- Assert i_Rst_L=0 mid-line at col 300 of locked frame.
  - All outputs 0 asynchronously.
  - After release, no o_Frame_Start until the first vs_lead; lock after 2 good frames.
- SYNC_ACTIVE_LOW=0 with inverted nominal stream gives results identical to the first scenario.
